// File: rtl/fir_out_decimator_if.sv
// Stream interface of the FIR output decimator: sample input, decimated
// valid/ready output and status flags.
interface fir_out_decimator_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int LVL_W = 3
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [LVL_W-1:0]        fifo_level;
    logic                    sat_pulse;
    logic                    overflow;

    // producer/consumer side of the decimator
    modport master (
        output in_valid, y_in, out_ready,
        input  out_valid, out_data, fifo_level, sat_pulse, overflow
    );

    // the decimator itself
    modport slave (
        input  in_valid, y_in, out_ready,
        output out_valid, out_data, fifo_level, sat_pulse, overflow
    );
endinterface

// File: rtl/fir_out_decimator.sv
// Boxcar (accumulate-and-dump) decimator for the FIR output stream.
// Each DECIM-sample frame sum is rounded half-up, shifted, saturated to
// OUT_W bits and queued in a small FIFO drained over valid/ready.
module fir_out_decimator #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    fir_out_decimator_if.slave bus
);
    localparam int PH_W  = $clog2(DECIM);
    localparam int ACC_W = IN_W + $clog2(DECIM) + 1;
    // one extra bit so the rounding offset can never wrap the sum
    localparam int RND_W = ACC_W + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(DECIM - 1);
    localparam logic [LVL_W-1:0] FULL_LV = LVL_W'(FIFO_DEPTH);

    logic [PH_W-1:0]         phase;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] y_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [RND_W-1:0] sum_w;
    logic signed [RND_W-1:0] shifted;
    logic signed [OUT_W-1:0] res;
    logic                    clamped;

    logic                    dump, full, pop, push, drop;
    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wptr, rptr;
    logic [LVL_W-1:0]        level;
    logic                    sat_q, ovf_q;

    assign y_ext = {{(ACC_W-IN_W){bus.y_in[IN_W-1]}}, bus.y_in};
    assign sum   = acc + y_ext;
    assign sum_w = {sum[ACC_W-1], sum};

    // round half up (toward +inf) then arithmetic shift
    if (SHIFT > 0) begin : g_round
        localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (SHIFT - 1);
        logic signed [RND_W-1:0] rnd;
        assign rnd     = sum_w + HALF;
        assign shifted = rnd >>> SHIFT;
    end else begin : g_noround
        assign shifted = sum_w;
    end

    // saturate to the signed OUT_W range
    if (OUT_W < RND_W) begin : g_clamp
        localparam logic signed [RND_W-1:0] MAXV = (RND_W'(1) << (OUT_W - 1)) - RND_W'(1);
        localparam logic signed [RND_W-1:0] MINV = ~MAXV;
        always_comb begin
            res     = shifted[OUT_W-1:0];
            clamped = 1'b0;
            if (shifted > MAXV) begin
                res     = MAXV[OUT_W-1:0];
                clamped = 1'b1;
            end else if (shifted < MINV) begin
                res     = MINV[OUT_W-1:0];
                clamped = 1'b1;
            end
        end
    end else begin : g_noclamp
        assign res     = OUT_W'(shifted);
        assign clamped = 1'b0;
    end

    // a full FIFO still takes a push when the head leaves on the same edge
    assign dump = bus.in_valid && (phase == LAST_PH);
    assign full = (level == FULL_LV);
    assign pop  = (level != '0) && bus.out_ready;
    assign push = dump && (!full || pop);
    assign drop = dump && full && !pop;

    // frame phase and running sum; both hold while in_valid is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            acc   <= '0;
        end else if (bus.in_valid) begin
            phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
            acc   <= (phase == '0) ? y_ext : sum;
        end
    end

    // result FIFO storage and pointers; pointers wrap naturally at AW bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= res;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // status: saturation pulse for accepted results, sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sat_q <= push && clamped;
            ovf_q <= ovf_q | drop;
        end
    end

    assign bus.out_valid  = (level != '0);
    assign bus.out_data   = mem[rptr];
    assign bus.fifo_level = level;
    assign bus.sat_pulse  = sat_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
Downstream stage of the FIR filter. Consumes the filter's signed 16-bit output stream and decimates it by DECIM using accumulate-and-dump (boxcar sum). Each frame sum is rounded, shifted and saturated to OUT_W bits. Results are buffered in a small FIFO and delivered over a valid/ready interface to the next consumer (DAC formatter / bus bridge).

Parameters:
IN_W, 16, width of signed input sample (FIR y_out)
OUT_W, 16, width of signed output sample
DECIM, 4, decimation factor, >= 2
SHIFT, 2, arithmetic right shift applied to frame sum, 0..ACC_W-1
FIFO_DEPTH, 4, output FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
in_valid  input  1  y_in carries a valid sample this cycle
y_in  input  IN_W  signed sample from FIR filter
out_valid  output  1  out_data holds a valid decimated sample
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  OUT_W  signed decimated sample (FIFO head)
fifo_level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
sat_pulse  output  1  one-cycle pulse: the pushed result was saturated
overflow  output  1  sticky: a result was dropped because FIFO was full

Behaviour:
- Reset (rst=0, async): phase=0, acc=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, sat_pulse=0, overflow=0. Partial frame discarded. Outputs stay at reset values while rst=0.
- ACC_W = IN_W + clog2(DECIM) + 1, signed, sign-extended input; no wrap possible.
- Phase counter 0..DECIM-1 advances only on in_valid; wraps DECIM-1 -> 0. in_valid=0 holds phase and acc.
- in_valid at phase 0: acc <= y_in (load). Phase 1..DECIM-2: acc <= acc + y_in.
- in_valid at phase DECIM-1 (dump): sum = acc + y_in (combinational); if SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, toward +inf); if SHIFT=0, r = sum. Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Push the clamped value on the same edge. sat_pulse=1 in the following cycle iff the clamp changed the value and the push was accepted.
- Latency: out_valid rises on the edge after the last sample of a frame when the FIFO was empty (1 cycle).
- Pop: out_valid && out_ready at an edge removes the head. out_valid = (fifo_level != 0). out_data is the registered FIFO head and is stable while out_valid=1 and out_ready=0.
- Push and pop on the same edge: both occur; fifo_level unchanged. This holds when full, so a push to a full FIFO with a simultaneous pop is accepted.
- Push to full FIFO without pop: the result is dropped. overflow <= 1 and stays 1 until reset. FIFO contents and fifo_level are unchanged. sat_pulse=0 for the dropped result.
- Pop when empty: ignored.
- Read/write pointers wrap modulo FIFO_DEPTH. Data order is strictly FIFO.
- Reset mid-frame or with a non-empty FIFO clears everything. The first frame after release starts at phase 0.

Test Plan:
1. Defaults; after reset, drive 100,100,100,100 with in_valid=1, out_ready=1 -> one result 100 (sum 400, (400+2)>>>2); out_valid high exactly 1 cycle after the 4th sample edge; sat_pulse=0.
2. Rounding and impulse: frames {1,0,0,0} -> 0; {1,1,0,0} -> 1; {-1,-1,0,0} -> 0; {-3,0,0,0} -> -1. Extremes: {32767 x4} -> 32767 and {-32768 x4} -> -32768, both with sat_pulse=0.
3. Saturation with SHIFT=0: {10000 x4} -> 32767 with sat_pulse=1 for one cycle; {-10000 x4} -> -32768 with sat_pulse=1.
4. Gapped input: in_valid toggled 1,0,0,1,1,0,1 carrying 5,x,x,5,5,x,5 -> single result 5; phase and acc hold during gaps.
5. Backpressure/overflow: out_ready=0, send 5 frames of constants 10,20,30,40,50 -> fifo_level=4, overflow=1 after 5th dump, out_data=10 held. Then out_ready=1 -> drains 10,20,30,40 in consecutive cycles, out_valid=0 after; overflow stays 1. Repeat with a simultaneous pop on the 5th dump -> 50 accepted, overflow=0.
6. Reset mid-frame: send 2 samples of 7, pull rst low for 1 cycle, release, send {8 x4} -> only result 8. fifo_level, out_valid and overflow are all 0 during reset.
